// File: rtl/weight_buf_loader.sv
`default_nettype none
// ============================================================================
// Module   : weight_buf_loader
// Brief    : Packs a weight stream into WPW-wide filter words and writes one
//            word per filter into the weight buffer RAM. Optional running
//            checksum is enabled with the WB_LOADER_CHECKSUM_EN macro.
// Revision : 1.0 - initial release
// ============================================================================
module weight_buf_loader #(
    parameter int M           = 8,
    parameter int NUM_FILTERS = 8,
    parameter int WPW         = 18
) (
    input  logic             clk,
    input  logic             Rst_n,
    input  logic             start,
    input  logic             in_valid,
    input  logic [M-1:0]     in_data,
    output logic             in_ready,
    output logic             wr_en,
    output logic [7:0]       wr_addr,
    output logic [M*WPW-1:0] wr_data,
    output logic             busy,
    output logic             load_done,
    output logic [15:0]      checksum
);

    localparam int               c_W         = M * WPW;
    localparam int               c_CNT_W     = $clog2(WPW + 1);
    localparam logic [c_CNT_W-1:0] c_WCNT_LAST = c_CNT_W'(WPW - 1);
    localparam logic [7:0]       c_IDX_LAST  = 8'(NUM_FILTERS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t               r_state;
    logic [c_CNT_W-1:0]   r_wcnt;
    logic [7:0]           r_idx;
    // Only the first WPW-1 weights need holding; the last arrives with the write.
    logic [c_W-M-1:0]     r_pack;
    logic                 r_wr_en;
    logic [7:0]           r_wr_addr;
    logic [c_W-1:0]       r_wr_data;

    logic                 w_hs;
    logic [c_W-1:0]       w_pack_next;

    assign w_hs        = in_valid && (r_state == FILL);
    assign w_pack_next = {r_pack, in_data};

    always_ff @(posedge clk) begin
        if (!Rst_n) begin
            r_state   <= IDLE;
            r_wcnt    <= '0;
            r_idx     <= '0;
            r_pack    <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_en <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= FILL;
                        r_wcnt  <= '0;
                        r_idx   <= '0;
                        r_pack  <= '0;
                    end
                end
                FILL: begin
                    if (w_hs) begin
                        r_pack <= w_pack_next[c_W-M-1:0];
                        if (r_wcnt == c_WCNT_LAST) begin
                            r_wcnt    <= '0;
                            r_state   <= WRITE;
                            r_wr_en   <= 1'b1;
                            r_wr_addr <= r_idx;
                            r_wr_data <= w_pack_next;
                        end else begin
                            r_wcnt <= r_wcnt + c_CNT_W'(1);
                        end
                    end
                end
                WRITE: begin
                    if (r_idx == c_IDX_LAST) begin
                        r_state <= DONE;
                    end else begin
                        r_idx   <= r_idx + 8'd1;
                        r_state <= FILL;
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == FILL);
    assign busy      = (r_state != IDLE);
    assign load_done = (r_state == DONE);
    assign wr_en     = r_wr_en;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;

`ifdef WB_LOADER_CHECKSUM_EN
    logic [15:0] r_checksum;

    always_ff @(posedge clk) begin
        if (!Rst_n) begin
            r_checksum <= '0;
        end else if (r_state == IDLE && start) begin
            r_checksum <= '0;
        end else if (w_hs) begin
            r_checksum <= r_checksum + 16'(in_data);
        end
    end

    assign checksum = r_checksum;
`else
    assign checksum = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_weight_buf_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_weight_buf_loader
// Brief    : Directed self-checking bench for weight_buf_loader.
// Revision : 1.0 - initial release
// ============================================================================
module tb_weight_buf_loader;

    localparam int c_W = 144;

    logic           clk = 1'b0;
    logic           Rst_n;
    logic           start;
    logic           in_valid;
    logic [7:0]     in_data;
    logic           in_ready;
    logic           wr_en;
    logic [7:0]     wr_addr;
    logic [c_W-1:0] wr_data;
    logic           busy;
    logic           load_done;
    logic [15:0]    checksum;

    weight_buf_loader dut (
        .clk       (clk),
        .Rst_n     (Rst_n),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .load_done (load_done),
        .checksum  (checksum)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc;
    int next_w;
    int done_cycle;
    int done_cnt;
    int rdy_in_write;
    int finished;
    int busy_after;

    logic [7:0]     log_addr[$];
    logic [c_W-1:0] log_data[$];

    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            log_addr.push_back(wr_addr);
            log_data.push_back(wr_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [c_W-1:0] obs, input logic [c_W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [c_W-1:0] exp_word(input int f);
        logic [c_W-1:0] e = '0;
        for (int j = 0; j < 18; j++) begin
            e = {e[c_W-9:0], 8'(18 * f + j + 1)};
        end
        return e;
    endfunction

    // Runs one load from a start pulse; optionally injects a stray start or stops early.
    task automatic run_load(input int gap, input int start_at, input int stop_w, input int budget);
        bit pulsed = 1'b0;
        bit hs;
        done_cycle   = -1;
        done_cnt     = 0;
        rdy_in_write = 0;
        finished     = 0;
        busy_after   = -1;
        in_valid     = 1'b0;
        start        = 1'b1;
        cyc          = 0;
        tick();
        start = 1'b0;
        for (int k = 0; k < budget; k++) begin
            if (load_done) begin
                done_cnt++;
                if (done_cycle < 0) done_cycle = cyc;
            end
            if (wr_en && in_ready) rdy_in_write++;
            if (stop_w != 0 && next_w == stop_w) begin
                finished = 1;
                break;
            end
            if (done_cycle >= 0 && cyc == done_cycle + 1) begin
                busy_after = int'(busy);
                finished   = 1;
                break;
            end
            start = (start_at >= 0 && !pulsed && log_addr.size() == start_at && in_ready);
            if (start) pulsed = 1'b1;
            in_valid = (gap != 0) ? (cyc % 3 != 0) : 1'b1;
            in_data  = 8'(next_w);
            hs       = in_valid && in_ready;
            tick();
            start = 1'b0;
            if (hs) next_w++;
        end
        in_valid = 1'b0;
    endtask

    task automatic check_log(input string tag);
        check({tag, " wr count"}, c_W'(log_addr.size()), c_W'(8));
        for (int i = 0; i < 8 && i < log_addr.size(); i++) begin
            check($sformatf("%s addr%0d", tag, i), c_W'(log_addr[i]), c_W'(i));
            check($sformatf("%s data%0d", tag, i), log_data[i], exp_word(i));
        end
    endtask

    initial begin
        logic [15:0] exp_sum;
`ifdef WB_LOADER_CHECKSUM_EN
        exp_sum = 16'd10440;
`else
        exp_sum = 16'd0;
`endif
        Rst_n    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'd0;
        cyc      = 0;
        tick();
        tick();
        check("rst in_ready", c_W'(in_ready), c_W'(0));
        check("rst wr_en", c_W'(wr_en), c_W'(0));
        check("rst busy", c_W'(busy), c_W'(0));
        check("rst load_done", c_W'(load_done), c_W'(0));
        check("rst wr_addr", c_W'(wr_addr), c_W'(0));
        check("rst wr_data", wr_data, '0);
        check("rst checksum", c_W'(checksum), c_W'(0));
        Rst_n = 1'b1;
        tick();

        // Back-to-back stream, in_valid stays high through WRITE cycles
        log_addr.delete(); log_data.delete(); next_w = 1;
        run_load(0, -1, 0, 400);
        check("t1 finished", c_W'(finished), c_W'(1));
        check("t1 done cycle", c_W'(done_cycle), c_W'(153));
        check("t1 done pulses", c_W'(done_cnt), c_W'(1));
        check("t1 busy after", c_W'(busy_after), c_W'(0));
        check("t1 ready in write", c_W'(rdy_in_write), c_W'(0));
        check_log("t1");
        check("t1 w00", c_W'(log_data[0][143:136]), c_W'(1));
        check("t1 w18", c_W'(log_data[0][7:0]), c_W'(18));
        check("t1 word1 w00", c_W'(log_data[1][143:136]), c_W'(19));
        check("t1 checksum", c_W'(checksum), c_W'(exp_sum));

        // Gapped stream
        tick();
        log_addr.delete(); log_data.delete(); next_w = 1;
        run_load(1, -1, 0, 800);
        check("t2 finished", c_W'(finished), c_W'(1));
        check("t2 done pulses", c_W'(done_cnt), c_W'(1));
        check_log("t2");
        check("t2 checksum", c_W'(checksum), c_W'(exp_sum));

        // Stray start during filter 3
        tick();
        log_addr.delete(); log_data.delete(); next_w = 1;
        run_load(0, 3, 0, 400);
        check("t3 finished", c_W'(finished), c_W'(1));
        check("t3 done cycle", c_W'(done_cycle), c_W'(153));
        check("t3 done pulses", c_W'(done_cnt), c_W'(1));
        check_log("t3");

        // Reset after 10 weights of filter 2
        tick();
        log_addr.delete(); log_data.delete(); next_w = 1;
        run_load(0, -1, 47, 400);
        check("t4 reached stop", c_W'(finished), c_W'(1));
        check("t4 writes before rst", c_W'(log_addr.size()), c_W'(2));
        Rst_n = 1'b0;
        tick();
        check("t4 busy", c_W'(busy), c_W'(0));
        check("t4 in_ready", c_W'(in_ready), c_W'(0));
        check("t4 wr_addr", c_W'(wr_addr), c_W'(0));
        check("t4 wr_data", wr_data, '0);
        Rst_n    = 1'b1;
        in_valid = 1'b1;
        for (int k = 0; k < 30; k++) tick();
        in_valid = 1'b0;
        check("t4 no wr after rst", c_W'(log_addr.size()), c_W'(2));
        check("t4 idle after rst", c_W'(busy), c_W'(0));
        log_addr.delete(); log_data.delete(); next_w = 1;
        run_load(0, -1, 0, 400);
        check("t4 reload finished", c_W'(finished), c_W'(1));
        check_log("t4 reload");
        check("t4 checksum", c_W'(checksum), c_W'(exp_sum));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/weight_buf_loader.md
WEIGHT_BUF_LOADER -- requirements
Module: weight_buf_loader

Interface
REQ-001 The block SHALL have parameter M, default 8, giving the width of one weight in bits.
REQ-002 The block SHALL have parameter NUM_FILTERS, default 8, giving the number of filter words per load (range 1..256).
REQ-003 The block SHALL have parameter WPW, default 18, giving the weights per buffer word (two rows of 9).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 The block SHALL have port Rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 The block SHALL have port start, input, 1 bit: one-cycle request to begin a load.
REQ-007 The block SHALL have port in_valid, input, 1 bit: in_data holds a weight.
REQ-008 The block SHALL have port in_data, input, M bits: one weight.
REQ-009 The block SHALL have port in_ready, output, 1 bit: the block accepts in_data this cycle.
REQ-010 The block SHALL have port wr_en, output, 1 bit: write strobe to the weight buffer RAM.
REQ-011 The block SHALL have port wr_addr, output, 8 bits: buffer word address, equal to the filter index.
REQ-012 The block SHALL have port wr_data, output, M*WPW bits: packed filter word.
REQ-013 The block SHALL have port busy, output, 1 bit: high whenever the FSM is not IDLE.
REQ-014 The block SHALL have port load_done, output, 1 bit: one-cycle pulse when all NUM_FILTERS words are written.
REQ-015 The block SHALL have port checksum, output, 16 bits: running weight sum (see Configuration).

Function
REQ-016 FSM states SHALL be IDLE, FILL, WRITE and DONE.
REQ-017 IDLE -> FILL SHALL occur on start=1; entry clears the weight counter, filter index and packing register.
REQ-018 start SHALL be ignored in every state except IDLE.
REQ-019 in_ready SHALL be 1 only in FILL; a handshake is in_valid & in_ready in the same cycle.
REQ-020 On each handshake the packing register SHALL shift left by M and place in_data in bits [M-1:0].
REQ-021 Packing order: first weight ends at [M*WPW-1:M*(WPW-1)] (reader slot W00); the 18th ends at [M-1:0] (slot W18).
REQ-022 On the WPW-th handshake FILL -> WRITE; wr_en=1 for exactly one cycle in WRITE, with wr_data=packed word and wr_addr=filter index.
REQ-023 in_ready SHALL be 0 in WRITE; in_valid held high in WRITE SHALL NOT be consumed.
REQ-024 WRITE -> FILL with index+1 if index < NUM_FILTERS-1; otherwise WRITE -> DONE.
REQ-025 DONE SHALL assert load_done for one cycle, then go to IDLE; busy SHALL be 0 from that IDLE cycle.
REQ-026 in_valid=0 in FILL SHALL stall without state change; gaps of any length are legal.
REQ-027 wr_en, wr_addr and wr_data SHALL be registered outputs; wr_addr and wr_data hold their last values outside WRITE.
REQ-028 Throughput: WPW accepted weights plus one WRITE cycle per filter; minimum load time is NUM_FILTERS*(WPW+1)+1 cycles after start.

Reset
REQ-029 On Rst_n=0 at a clock edge: state=IDLE; in_ready, wr_en, busy, load_done=0; wr_addr=0; wr_data=0; checksum=0; counters cleared.
REQ-030 Reset mid-load SHALL discard any partial word and SHALL NOT emit wr_en; a new start is required afterwards.

Configuration
REQ-031 Macro WB_LOADER_CHECKSUM_EN defined: checksum is cleared on IDLE->FILL and adds zero-extended in_data on each handshake, modulo 2^16; it is held after DONE until the next start or reset.
REQ-032 Macro WB_LOADER_CHECKSUM_EN undefined: checksum SHALL be constant 0 and no adder logic SHALL be built.

Verification
REQ-033 Reset then start, 144 weights 1..144 with in_valid always high -> 8 wr_en pulses, addr 0..7; word 0 slot W00=1 and W18=18; load_done at cycle 153 after start.
REQ-034 Same stream with in_valid dropped every third cycle -> identical wr_data/wr_addr sequence, no lost or duplicated weight.
REQ-035 in_valid held high across a WRITE cycle -> in_ready=0 in that cycle; the 19th weight lands in word 1 slot W00.
REQ-036 start pulsed during FILL of filter 3 -> no restart; addresses continue 3..7; exactly one load_done.
REQ-037 Rst_n=0 after 10 weights of filter 2 -> no further wr_en, busy=0 next cycle; a new load starts from addr 0.
REQ-038 With WB_LOADER_CHECKSUM_EN defined, weights 1..144 -> checksum=10440 after load_done; undefined -> checksum stays 0.
